// File: rtl/alu_mdu_seq.sv
// EX-stage ALU + RV32M unit: decodes aluop/funct3/funct7 and executes, base ops in 1 cycle, mul/div iteratively.
// Latency 1 (base/illegal/div special cases) or XLEN+2 (M ops); ready_o only when idle, requests while busy are dropped.
module alu_mdu_seq #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic            op5,
    input  logic [1:0]      aluop,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o,
    output logic            illegal_o
);

    localparam int SW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MD
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_EXEC_BASE, S_ITER, S_FIN} state_t;

    state_t            state, state_d;
    op_t               dec_op, op_q;
    logic              dec_ill, dec_special, accept;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2:0]        f3_q;
    logic              ill_q, prep_q;
    logic [SW-1:0]     cnt_q;
    logic [2*XLEN-1:0] prod_q;

    assign ready_o = (state == S_IDLE);
    assign accept  = valid_i && ready_o && !flush_i;

    always_comb begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (aluop)
            2'd0: dec_op = OP_ADD;
            2'd1: begin
                case (funct3[2:1])
                    2'b00:   dec_op = OP_SUB;
                    2'b10:   dec_op = OP_SLT;
                    2'b11:   dec_op = OP_SLTU;
                    default: dec_ill = 1'b1;
                endcase
            end
            2'd2: begin
                if (op5 && funct7 == 7'b0000001) begin
                    dec_op  = OP_MD;
                    dec_ill = !ENABLE_M;
                end else begin
                    case (funct3)
                        3'b000:  dec_op = (op5 && funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b010:  dec_op = OP_SLT;
                        3'b011:  dec_op = OP_SLTU;
                        3'b100:  dec_op = OP_XOR;
                        3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        default: dec_op = OP_AND;
                    endcase
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Divide-by-zero and signed overflow have fixed answers and skip the iteration.
    assign dec_special = funct3[2] &&
                         (src_b == '0 || (!funct3[0] && src_a == MOST_NEG && src_b == '1));

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d = (dec_op == OP_MD && !dec_ill && !dec_special) ? S_ITER : S_EXEC_BASE;
                end
            end
            S_EXEC_BASE: state_d = S_IDLE;
            S_ITER: begin
                if (!prep_q && cnt_q == SW'(XLEN-1)) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i && state != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] base_res;

    assign shamt = b_q[SW-1:0];

    always_comb begin
        base_res = '0;
        case (op_q)
            OP_ADD:  base_res = a_q + b_q;
            OP_SUB:  base_res = a_q - b_q;
            OP_SLL:  base_res = a_q << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            OP_XOR:  base_res = a_q ^ b_q;
            OP_SRL:  base_res = a_q >> shamt;
            OP_SRA:  base_res = $unsigned($signed(a_q) >>> shamt);
            OP_OR:   base_res = a_q | b_q;
            OP_AND:  base_res = a_q & b_q;
            OP_MD: begin
                if (b_q == '0) begin
                    base_res = f3_q[1] ? a_q : '1;
                end else begin
                    base_res = f3_q[1] ? '0 : MOST_NEG;
                end
            end
            default: base_res = '0;
        endcase
    end

    // M datapath works on magnitudes; signedness of each operand comes from funct3.
    logic              a_sgn, b_sgn, sa, sb, neg;
    logic [XLEN-1:0]   ma, mb, mq;
    logic [XLEN:0]     mul_sum, div_shl, div_diff;
    logic [2*XLEN-1:0] step_nxt, ps;
    logic [XLEN-1:0]   fin_res;

    always_comb begin
        a_sgn    = !(f3_q == 3'b011 || (f3_q[2] && f3_q[0]));
        b_sgn    = a_sgn && (f3_q != 3'b010);
        sa       = a_sgn && a_q[XLEN-1];
        sb       = b_sgn && b_q[XLEN-1];
        neg      = (f3_q[2] && f3_q[1]) ? sa : (sa ^ sb);
        ma       = sa ? -a_q : a_q;
        mb       = sb ? -b_q : b_q;
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? ma : {XLEN{1'b0}})};
        div_shl  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff = div_shl - {1'b0, mb};
        if (f3_q[2]) begin
            step_nxt = {(div_diff[XLEN] ? div_shl[XLEN-1:0] : div_diff[XLEN-1:0]),
                        prod_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_nxt = {mul_sum, prod_q[XLEN-1:1]};
        end
        ps = neg ? -prod_q : prod_q;
        mq = f3_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        if (!f3_q[2]) begin
            fin_res = (f3_q[1:0] == 2'b00) ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN];
        end else begin
            fin_res = neg ? -mq : mq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            f3_q      <= '0;
            ill_q     <= 1'b0;
            prep_q    <= 1'b0;
            cnt_q     <= '0;
            prod_q    <= '0;
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (accept) begin
                a_q    <= src_a;
                b_q    <= src_b;
                op_q   <= dec_op;
                f3_q   <= funct3;
                ill_q  <= dec_ill;
                prep_q <= 1'b1;
                cnt_q  <= '0;
            end
            // First ITER cycle only loads magnitudes, keeping negation off the accept path.
            if (state == S_ITER) begin
                if (prep_q) begin
                    prod_q <= {{XLEN{1'b0}}, (f3_q[2] ? ma : mb)};
                    prep_q <= 1'b0;
                end else begin
                    prod_q <= step_nxt;
                    cnt_q  <= cnt_q + SW'(1);
                end
            end
            if (!flush_i) begin
                if (state == S_EXEC_BASE) begin
                    result_o  <= ill_q ? '0 : base_res;
                    zero_o    <= ill_q || (base_res == '0);
                    illegal_o <= ill_q;
                    valid_o   <= 1'b1;
                end else if (state == S_FIN) begin
                    result_o  <= fin_res;
                    zero_o    <= (fin_res == '0);
                    illegal_o <= 1'b0;
                    valid_o   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOP/funct3/funct7 into an extended 4-bit op code covering RV32I ALU ops, branch compares, and RV32M multiply/divide.
- Executes the decoded op: base ops finish in 1 cycle; M ops run an iterative shift-add / restoring-divide datapath.
- Sits in the EX stage of the multi-cycle core with a valid/ready handshake toward the control FSM.

Parameters:
- XLEN, 32, operand/result width; must be ≥4 and even.
- ENABLE_M, 1, 1 = decode and execute RV32M ops; 0 = M encodings raise illegal_o.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid; accepted when valid_i && ready_o.
- flush_i  in  1  abort any in-flight op; no valid_o is produced for it.
- op5  in  1  instruction bit 5 (R-type vs I-type).
- aluop  in  2  0 = add (load/store/jal), 1 = branch, 2 = R/I arithmetic, 3 = reserved.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- src_a  in  XLEN  operand A.
- src_b  in  XLEN  operand B.
- ready_o  out  1  idle, can accept a request.
- valid_o  out  1  one-cycle pulse; result_o, zero_o and illegal_o are valid.
- result_o  out  XLEN  result, held until the next valid_o.
- zero_o  out  1  result_o == 0, registered with the result.
- illegal_o  out  1  decoded encoding unsupported; result_o = 0.

Behaviour:
- Reset values: ready_o = 1, valid_o = 0, result_o = 0, zero_o = 0, illegal_o = 0, FSM = IDLE.
- Reset is asynchronous and may assert mid-operation; the iteration is abandoned with no valid_o.
- Decode (latched at accept):
  - aluop 0: ADD.
  - aluop 1 (branch compares): funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → illegal.
  - aluop 2, base ops (funct7 not 0000001):
    - funct3 000: SUB if {op5, funct7[5]} = 11, else ADD.
    - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
    - 101 → SRA if funct7[5], else SRL.
    - 110 → OR; 111 → AND.
  - aluop 2, M ops (op5 = 1 and funct7 = 0000001):
    - funct3 000–011 → MUL/MULH/MULHSU/MULHU.
    - funct3 100–111 → DIV/DIVU/REM/REMU.
    - Illegal if ENABLE_M = 0.
  - aluop 3: illegal.
- Shift amount is src_b[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1, zero-extended.
- FSM states:
  - IDLE: accept → EXEC_BASE for base, illegal and special-case ops; → ITER for M ops.
  - EXEC_BASE: 1 cycle; result registered, valid_o, → IDLE. Latency is valid_o 1 cycle after accept, and ready_o returns in the same cycle as valid_o.
  - ITER: XLEN iterations, one bit per cycle, counter 0..XLEN-1, then FIN.
  - FIN: sign-correct the result, valid_o, → IDLE. Total M latency is XLEN+2 cycles from accept to valid_o.
- ready_o = 1 only in IDLE. valid_i while busy is ignored, not queued.
- Multiply:
  - Operate on magnitudes; the signedness of A/B comes from funct3.
  - Produce a 2·XLEN product.
  - MUL returns the low half; the others return the high half.
  - Negate at FIN when the operand signs differ.
- Divide (restoring, on magnitudes):
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Special cases complete via EXEC_BASE (1-cycle latency):
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → src_a.
  - Signed overflow (A = most-negative, B = −1): DIV → most-negative; REM → 0.
- flush_i:
  - In ITER, EXEC_BASE or FIN: → IDLE next cycle, valid_o suppressed, result_o unchanged.
  - In IDLE: a simultaneous valid_i is dropped.
- Operands are captured at accept; later changes on src_a/src_b have no effect.

Test Plan:
- Reset, then aluop=2, funct3=000, op5=1, funct7=0100000, A=5, B=7 → valid_o 1 cycle later, result=0xFFFFFFFE, zero_o=0, ready_o high the same cycle.
- aluop=1, funct3=100, A=0xFFFFFFFF, B=1 → result=1 (SLT); funct3=110 with the same operands → result=0 (SLTU).
- MULH, A=0x80000000, B=2 → valid_o exactly 34 cycles after accept, result=0xFFFFFFFF; ready_o low throughout, and a second valid_i in that window is ignored.
- DIV, A=0x80000000, B=0xFFFFFFFF → result=0x80000000 at 1-cycle latency; REMU, A=9, B=0 → result=9; DIV, A=−7, B=2 → result=−3; REM with the same operands → result=−1.
- DIVU in flight, flush_i pulsed at iteration 10 → no valid_o, ready_o=1 next cycle; rst_n low mid-MUL → all outputs at reset values immediately, asynchronously.
- ENABLE_M=0: MUL encoding → illegal_o=1, result=0, 1-cycle latency; aluop=3 → illegal_o=1.
